wb_arbiter2: RTL and testbench

//  Two-master, one-slave Wishbone (classic) arbiter placed in front of the SPI SRAM controller.
//  m0 is the UART-to-Wishbone bridge (host access). m1 is the Levenshtein compute engine (word-list fetch).

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_arb_watchdog.sv | 49 ++++
 rtl/wb_arbiter2.sv | 186 ++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
//   Shared definitions for the two-master Wishbone arbiter (wb_arbiter2) and
//   its optional stall watchdog (wb_arb_watchdog).
//   Contents:
//     arb_state_e     FSM state encoding (IDLE / GNT0 / GNT1)
//     ARB_ADDR_WIDTH  default Wishbone byte-address width (SRAM space)
//     ARB_DATA_WIDTH  default Wishbone data width
//     GNT_IDX_W       width of a grant index (two masters -> 1 bit)
//     WDOG_CNT_W      width of the stall watchdog counter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int ARB_ADDR_WIDTH = 23;
  localparam int ARB_DATA_WIDTH = 8;
  localparam int GNT_IDX_W      = 1;
  localparam int WDOG_CNT_W     = 8;

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog
//   Stall timer for the arbiter. Counts cycles in which the granted master has
//   a strobe outstanding and the slave gives no termination. When the count
//   reaches TIMEOUT_CYCLES, timeout is high for one cycle and the count clears.
//   Ports:
//     clk_i    in   clock
//     rst_n    in   synchronous active-low reset (clears the count)
//     stall    in   strobe outstanding with no ack/err/rty this cycle
//     term     in   any slave termination this cycle (clears the count)
//     clear    in   no grant held or grant changing (clears the count)
//     timeout  out  count has reached TIMEOUT_CYCLES (registered, one cycle)
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic stall,
  input  logic term,
  input  logic clear,
  output logic timeout
);

  logic [WDOG_CNT_W-1:0] count_reg;
  logic [WDOG_CNT_W-1:0] count_next;

  // Decoded from the register only, so the forced strobe/err it drives in
  // the top level cannot loop back into the stall input combinationally.
  assign timeout = (count_reg == WDOG_CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    count_next = count_reg;
    if (term || clear || timeout) begin
      count_next = '0;
    end else if (stall) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2
//   Two-master, one-slave Wishbone (classic) arbiter in front of the SPI SRAM
//   controller. m0 = UART-to-Wishbone bridge, m1 = Levenshtein engine.
//   Round-robin grant, locked for the whole cyc burst; the winner's bus is
//   muxed onto the slave side and the slave terminations go back to it only.
//   Optional feature macro: WB_ARB_TIMEOUT_EN -- builds wb_arb_watchdog, which
//   forces a one-cycle err to the owner after TIMEOUT_CYCLES stalled cycles.
//   Ports:
//     clk_i, rst_n                     clock, synchronous active-low reset
//     mN_cyc_i/stb_i/we_i/adr_i/dat_i  master N request (N = 0, 1)
//     mN_ack_o/err_o/rty_o             master N terminations (owner only)
//     mN_dat_o                         slave read data, broadcast
//     s_cyc_o/stb_o/we_o/adr_o/dat_o   request to the slave
//     s_ack_i/err_i/rty_i/dat_i        slave response
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i
);

  arb_state_e           state_reg;
  arb_state_e           state_next;
  logic [GNT_IDX_W-1:0] last_grant_reg;
  logic [GNT_IDX_W-1:0] last_grant_next;
  logic                 stb_raw;
  logic                 timeout;

  // ---------------------------------------------------------------------------
  // Grant FSM. A release always passes through IDLE, which gives the dead
  // cycle between owners and lets the round-robin decision see both requests.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          // Tie: the master that did not win last time gets the bus.
          if (last_grant_reg == GNT_IDX_W'(1)) begin
            state_next      = GNT0;
            last_grant_next = GNT_IDX_W'(0);
          end else begin
            state_next      = GNT1;
            last_grant_next = GNT_IDX_W'(1);
          end
        end else if (m0_cyc_i) begin
          state_next      = GNT0;
          last_grant_next = GNT_IDX_W'(0);
        end else if (m1_cyc_i) begin
          state_next      = GNT1;
          last_grant_next = GNT_IDX_W'(1);
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_next = IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= GNT_IDX_W'(1);
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus muxes, combinational from the registered grant. s_cyc_o follows the
  // owner's cyc directly so an abort reaches the slave in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc_o  = 1'b0;
    stb_raw  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (state_reg)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        stb_raw  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | timeout;
        m0_rty_o = s_rty_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        stb_raw  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | timeout;
        m1_rty_o = s_rty_i;
      end
      default: begin
      end
    endcase
    // On a watchdog timeout the strobe is withdrawn so the slave does not
    // complete an access the master has already been told failed.
    s_stb_o = stb_raw & ~timeout;
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  logic stall;
  logic term;
  logic wdog_clear;

  assign term       = s_ack_i | s_err_i | s_rty_i;
  assign stall      = s_cyc_o & stb_raw & ~term;
  assign wdog_clear = (state_next != state_reg) || (state_reg == IDLE);

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .stall  (stall),
    .term   (term),
    .clear  (wdog_clear),
    .timeout(timeout)
  );
`else
  // No watchdog: a stalled slave holds the owner until it answers.
  logic [7:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2
//   Self-checking bench for wb_arbiter2: directed scenarios (reset, single
//   read, simultaneous requests, locked burst, abort, mid-cycle reset, stall
//   timeout) followed by randomized traffic. A bus-ownership reference model
//   predicts every slave-side and master-side output each cycle.
//   Honours WB_ARB_TIMEOUT_EN for the stall scenario.
module tb_wb_arbiter2;
  localparam int AW = 23;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [AW-1:0] m0_adr_i = '0;
  logic [DW-1:0] m0_dat_i = '0;
  logic          m0_ack_o, m0_err_o, m0_rty_o;
  logic [DW-1:0] m0_dat_o;
  logic          m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [AW-1:0] m1_adr_i = '0;
  logic [DW-1:0] m1_dat_i = '0;
  logic          m1_ack_o, m1_err_o, m1_rty_o;
  logic [DW-1:0] m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic          s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  logic [DW-1:0] s_dat_i = '0;

  always #5 clk_i = ~clk_i;

  wb_arbiter2 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the bus (-1 = nobody) and who won last.
  // ---------------------------------------------------------------------------
  int owner = -1;
  int last = 1;
  int stall_run = 0;
  bit mdl_en = 1'b0;

  always @(posedge clk_i) begin
    if (!rst_n) begin
      owner = -1;
      last = 1;
      stall_run = 0;
    end else begin
      if (owner >= 0 &&
          ((owner == 0) ? (m0_cyc_i && m0_stb_i) : (m1_cyc_i && m1_stb_i)) &&
          !(s_ack_i || s_err_i || s_rty_i))
        stall_run++;
      else
        stall_run = 0;
      if (owner < 0) begin
        if (m0_cyc_i && m1_cyc_i) owner = 1 - last;
        else if (m0_cyc_i) owner = 0;
        else if (m1_cyc_i) owner = 1;
        if (owner >= 0) begin
          last = owner;
          stall_run = 0;
        end
      end else if ((owner == 0 && !m0_cyc_i) || (owner == 1 && !m1_cyc_i)) begin
        owner = -1;
      end
    end
  end

  always @(negedge clk_i) begin
    logic [8:0]    e_ctl;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    if (mdl_en) begin
      e_ctl = '0;
      e_adr = '0;
      e_dat = '0;
      if (owner == 0) begin
        e_ctl = {m0_cyc_i, m0_stb_i, m0_we_i, s_ack_i, s_err_i, s_rty_i, 3'b000};
        e_adr = m0_adr_i;
        e_dat = m0_dat_i;
      end else if (owner == 1) begin
        e_ctl = {m1_cyc_i, m1_stb_i, m1_we_i, 3'b000, s_ack_i, s_err_i, s_rty_i};
        e_adr = m1_adr_i;
        e_dat = m1_dat_i;
      end
      check("mdl_ctl", {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m0_rty_o,
                        m1_ack_o, m1_err_o, m1_rty_o}, e_ctl);
      check("mdl_adr", s_adr_o, e_adr);
      check("mdl_wdat", s_dat_o, e_dat);
      check("mdl_rdat", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int beats, m0_acks, errs, first_err;

    // ---- reset held 3 cycles with m0 requesting ----
    rst_n = 1'b0;
    m0_cyc_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      mdl_en = 1'b1;
      if (i == 2) rst_n = 1'b1;
      @(negedge clk_i);
      check("rst_scyc_low", {s_cyc_o, m0_ack_o, m1_ack_o}, 3'b000);
    end
    tick();
    @(negedge clk_i);
    check("rst_release_lat", s_cyc_o, 1'b1);

    // ---- single m0 read, slave acks on the 4th strobe cycle ----
    tick();
    m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 23'h000010;
    tick();
    tick();
    tick();
    s_ack_i = 1'b1; s_dat_i = 8'hA5;
    @(negedge clk_i);
    check("read_ack", {m0_ack_o, m1_ack_o}, 2'b10);
    check("read_data", m0_dat_o, 8'hA5);
    tick();
    s_ack_i = 1'b0; s_dat_i = '0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    tick();

    // ---- simultaneous requests after reset: m0 first, then m1 ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 23'h000100; m0_dat_i = 8'h11;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 23'h000200; m1_dat_i = 8'h22;
    @(negedge clk_i);
    check("both_idle", s_cyc_o, 1'b0);
    tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    check("both_m0_first", {s_cyc_o, s_adr_o, s_dat_o}, {1'b1, 23'h000100, 8'h11});
    check("both_m0_ack", {m0_ack_o, m1_ack_o}, 2'b10);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk_i);
    check("both_drop_adr", {s_cyc_o, s_adr_o}, {1'b0, 23'h000100});
    tick();
    @(negedge clk_i);
    check("both_dead", {s_cyc_o, s_adr_o}, 24'h0);
    tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    check("both_m1_second", {s_cyc_o, s_adr_o, s_dat_o}, {1'b1, 23'h000200, 8'h22});
    check("both_m1_ack", {m0_ack_o, m1_ack_o}, 2'b01);
    tick();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    tick();

    // ---- m1 4-beat burst with an stb gap while m0 waits ----
    m1_cyc_i = 1'b1; m1_we_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 23'h000300;
    beats = 0;
    m0_acks = 0;
    for (int p = 0; p < 5; p++) begin
      m1_stb_i = (p != 2);
      s_ack_i  = (p != 2);
      m1_adr_i = AW'(23'h000400 + p);
      @(negedge clk_i);
      if (m1_ack_o) beats++;
      if (m0_ack_o) m0_acks++;
      tick();
    end
    check("burst_beats", beats, 4);
    check("burst_m0_ack", m0_acks, 0);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    @(negedge clk_i);
    check("burst_release", s_cyc_o, 1'b0);
    tick();
    @(negedge clk_i);
    check("burst_dead", s_cyc_o, 1'b0);
    tick();
    @(negedge clk_i);
    check("burst_m0_after2", {s_cyc_o, s_adr_o}, {1'b1, 23'h000300});

    // ---- m0 aborts before ack; late ack goes nowhere ----
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk_i);
    check("abort_scyc", s_cyc_o, 1'b0);
    tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    check("abort_late_ack", {m0_ack_o, m1_ack_o}, 2'b00);
    tick();
    s_ack_i = 1'b0;

    // ---- reset asserted while m1 holds the bus ----
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("midrst_pre", s_cyc_o, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk_i);
    check("midrst_post", s_cyc_o, 1'b0);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    tick();

    // ---- slave never answers ----
    m0_cyc_i = 1'b1; m0_we_i = 1'b0; m0_adr_i = 23'h000040;
    tick();
    m0_stb_i = 1'b1;
    errs = 0;
    first_err = -1;
`ifdef WB_ARB_TIMEOUT_EN
    mdl_en = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      if (m0_err_o) begin
        errs++;
        if (first_err < 0) first_err = k;
      end
      tick();
      if (errs != 0) begin
        m0_cyc_i = 1'b0;
        m0_stb_i = 1'b0;
      end
    end
    check("timeout_delay", first_err, 8);
    check("timeout_pulses", errs, 1);
    tick();
    mdl_en = 1'b1;
`else
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_i);
      if (m0_err_o) errs++;
      tick();
    end
    check("no_timeout_err", errs, 0);
    check("stall_still_owned", {s_cyc_o, s_stb_o}, 2'b11);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
`endif
    tick();

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(5) != 0);
      else          m0_cyc_i = ($urandom_range(2) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(5) != 0);
      else          m1_cyc_i = ($urandom_range(2) == 0);
      m0_stb_i = m0_cyc_i && ($urandom_range(3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(3) != 0);
      m0_we_i  = 1'($urandom);
      m1_we_i  = 1'($urandom);
      m0_adr_i = AW'($urandom);
      m1_adr_i = AW'($urandom);
      m0_dat_i = DW'($urandom);
      m1_dat_i = DW'($urandom);
      // Keep stalls short so the optional watchdog never fires here.
      s_ack_i  = ($urandom_range(2) == 0) || (stall_run >= 4);
      s_err_i  = ($urandom_range(15) == 0);
      s_rty_i  = ($urandom_range(15) == 0);
      s_dat_i  = DW'($urandom);
    end
    tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    tick();
    tick();
    @(negedge clk_i);
    check("final_idle", s_cyc_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
